// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath bundle for the multicycle MIPS controller
interface multicycle_control_if;
  logic [5:0]  OpCode;
  logic        Zero;
  logic        mem_ready;
  logic        PCwe;
  logic        IRwe;
  logic        RFwe;
  logic        DMwe;
  logic        DMre;
  logic [1:0]  ALUS;
  logic        IorD;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        RegDst;
  logic        MemtoReg;
  logic        PCSrc;
  logic        trap;
  logic [3:0]  state;
  logic [31:0] retired;

  // master is the controller, slave is the datapath/memory side
  modport master (
    input  OpCode, Zero, mem_ready,
    output PCwe, IRwe, RFwe, DMwe, DMre, ALUS, IorD, ALUSrcA, ALUSrcB,
           RegDst, MemtoReg, PCSrc, trap, state, retired
  );
  modport slave (
    output OpCode, Zero, mem_ready,
    input  PCwe, IRwe, RFwe, DMwe, DMre, ALUS, IorD, ALUSrcA, ALUSrcB,
           RegDst, MemtoReg, PCSrc, trap, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory stall, trap and retire counter
module multicycle_control (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_if.master       bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.OpCode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (bus.OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin retire = 1'b1; state_d = S_FETCH; end
      S_MEMWR:  if (bus.mem_ready) begin retire = 1'b1; state_d = S_FETCH; end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  begin retire = 1'b1; state_d = S_FETCH; end
      S_BRANCH: begin retire = 1'b1; state_d = S_FETCH; end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  assign retired_d = retired_q + {31'd0, retire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  logic       pc_we, ir_we, rf_we, dm_we, dm_re, iord, src_a, reg_dst, mem_to_reg, pc_src, trap;
  logic [1:0] alus, src_b;

  // Everything is decoded from the state, except PCwe/IRwe which also look at mem_ready/Zero
  always_comb begin
    pc_we = 1'b0; ir_we = 1'b0; rf_we = 1'b0; dm_we = 1'b0; dm_re = 1'b0;
    iord = 1'b0; src_a = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0; pc_src = 1'b0;
    trap = 1'b0; alus = 2'd0; src_b = 2'd0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          dm_re = 1'b1;
          src_b = 2'd1;
          ir_we = bus.mem_ready;
          pc_we = bus.mem_ready;
        end
        S_DECODE: src_b = 2'd3;
        S_MEMADR: begin src_a = 1'b1; src_b = 2'd2; end
        S_MEMRD:  begin dm_re = 1'b1; iord = 1'b1; end
        S_MEMWB:  begin rf_we = 1'b1; mem_to_reg = 1'b1; end
        S_MEMWR:  begin dm_we = 1'b1; iord = 1'b1; end
        S_EXEC:   begin src_a = 1'b1; alus = 2'd2; end
        S_ALUWB:  begin rf_we = 1'b1; reg_dst = 1'b1; end
        S_BRANCH: begin
          src_a  = 1'b1;
          alus   = 2'd1;
          pc_src = 1'b1;
          pc_we  = bus.Zero;
        end
        S_TRAP:   trap = 1'b1;
        default:  ;
      endcase
    end
  end

  assign bus.PCwe     = pc_we;
  assign bus.IRwe     = ir_we;
  assign bus.RFwe     = rf_we;
  assign bus.DMwe     = dm_we;
  assign bus.DMre     = dm_re;
  assign bus.ALUS     = alus;
  assign bus.IorD     = iord;
  assign bus.ALUSrcA  = src_a;
  assign bus.ALUSrcB  = src_b;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.PCSrc    = pc_src;
  assign bus.trap     = trap;
  assign bus.state    = state_q;
  assign bus.retired  = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // control word: PCwe IRwe RFwe DMwe DMre ALUS[2] IorD SrcA SrcB[2] RegDst MemtoReg PCSrc trap
  localparam logic [14:0] CW_ZERO = 15'b0_0_0_0_0_00_0_0_00_0_0_0_0;
  localparam logic [14:0] CW_FS   = 15'b0_0_0_0_1_00_0_0_01_0_0_0_0;
  localparam logic [14:0] CW_FR   = 15'b1_1_0_0_1_00_0_0_01_0_0_0_0;
  localparam logic [14:0] CW_DEC  = 15'b0_0_0_0_0_00_0_0_11_0_0_0_0;
  localparam logic [14:0] CW_MA   = 15'b0_0_0_0_0_00_0_1_10_0_0_0_0;
  localparam logic [14:0] CW_MR   = 15'b0_0_0_0_1_00_1_0_00_0_0_0_0;
  localparam logic [14:0] CW_MWB  = 15'b0_0_1_0_0_00_0_0_00_0_1_0_0;
  localparam logic [14:0] CW_MW   = 15'b0_0_0_1_0_00_1_0_00_0_0_0_0;
  localparam logic [14:0] CW_EX   = 15'b0_0_0_0_0_10_0_1_00_0_0_0_0;
  localparam logic [14:0] CW_AWB  = 15'b0_0_1_0_0_00_0_0_00_1_0_0_0;
  localparam logic [14:0] CW_BT   = 15'b1_0_0_0_0_01_0_1_00_0_0_1_0;
  localparam logic [14:0] CW_BN   = 15'b0_0_0_0_0_01_0_1_00_0_0_1_0;
  localparam logic [14:0] CW_TRAP = 15'b0_0_0_0_0_00_0_0_00_0_0_0_1;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] cw;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc_n, act, exp);
    end
  endtask

  // monitor: one expected entry per clock, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [14:0] cw;
      e  = exp_q.pop_front();
      cw = {bus.PCwe, bus.IRwe, bus.RFwe, bus.DMwe, bus.DMre, bus.ALUS, bus.IorD,
            bus.ALUSrcA, bus.ALUSrcB, bus.RegDst, bus.MemtoReg, bus.PCSrc, bus.trap};
      chk("state", {28'd0, bus.state}, {28'd0, e.st});
      chk("ctrl", {17'd0, cw}, {17'd0, e.cw});
      chk("retired", bus.retired, e.ret);
      cyc_n++;
    end
  end

  task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [14:0] cw, input logic [31:0] ret);
    rst_n         = r;
    bus.OpCode    = op;
    bus.Zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back({st, cw, ret});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc_n);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    bus.OpCode = 6'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // reset state, even with mem_ready high
    cyc(0, 6'd0, 0, 1, 4'd0, CW_ZERO, 0);
    cyc(0, 6'd0, 0, 0, 4'd0, CW_ZERO, 0);
    // R-type: 0,1,6,7,0 ; mem_ready noise outside FETCH is ignored
    cyc(1, 6'd0, 0, 1, 4'd0, CW_FR,  0);
    cyc(1, 6'd0, 0, 0, 4'd1, CW_DEC, 0);
    cyc(1, 6'd0, 1, 0, 4'd6, CW_EX,  0);
    cyc(1, 6'd0, 0, 0, 4'd7, CW_AWB, 0);
    // lw with two stall cycles in MEMRD
    cyc(1, 6'd35, 0, 1, 4'd0, CW_FR,  1);
    cyc(1, 6'd35, 0, 1, 4'd1, CW_DEC, 1);
    cyc(1, 6'd35, 0, 1, 4'd2, CW_MA,  1);
    cyc(1, 6'd35, 0, 0, 4'd3, CW_MR,  1);
    cyc(1, 6'd35, 0, 0, 4'd3, CW_MR,  1);
    cyc(1, 6'd35, 0, 1, 4'd3, CW_MR,  1);
    cyc(1, 6'd35, 0, 1, 4'd4, CW_MWB, 1);
    // sw with one stall cycle in FETCH
    cyc(1, 6'd43, 0, 0, 4'd0, CW_FS,  2);
    cyc(1, 6'd43, 0, 1, 4'd0, CW_FR,  2);
    cyc(1, 6'd43, 0, 0, 4'd1, CW_DEC, 2);
    cyc(1, 6'd43, 0, 0, 4'd2, CW_MA,  2);
    cyc(1, 6'd43, 0, 1, 4'd5, CW_MW,  2);
    // beq taken then not taken
    cyc(1, 6'd4, 1, 1, 4'd0, CW_FR,  3);
    cyc(1, 6'd4, 1, 1, 4'd1, CW_DEC, 3);
    cyc(1, 6'd4, 1, 1, 4'd8, CW_BT,  3);
    cyc(1, 6'd4, 0, 1, 4'd0, CW_FR,  4);
    cyc(1, 6'd4, 0, 1, 4'd1, CW_DEC, 4);
    cyc(1, 6'd4, 0, 1, 4'd8, CW_BN,  4);
    // sw interrupted by reset while stalled in MEMWR
    cyc(1, 6'd43, 0, 1, 4'd0, CW_FR,  5);
    cyc(1, 6'd43, 0, 1, 4'd1, CW_DEC, 5);
    cyc(1, 6'd43, 0, 1, 4'd2, CW_MA,  5);
    cyc(1, 6'd43, 0, 0, 4'd5, CW_MW,  5);
    cyc(0, 6'd43, 0, 0, 4'd0, CW_ZERO, 0);
    cyc(0, 6'd43, 0, 1, 4'd0, CW_ZERO, 0);
    // unsupported opcode: trap is sticky, nothing retires
    cyc(1, 6'd2, 0, 1, 4'd0, CW_FR,  0);
    cyc(1, 6'd2, 0, 1, 4'd1, CW_DEC, 0);
    for (int i = 0; i < 20; i++)
      cyc(1, 6'd2, i[0], i[1], 4'd9, CW_TRAP, 0);
    cyc(0, 6'd2, 0, 1, 4'd0, CW_ZERO, 0);
    // back to normal: R-type after trap recovery
    cyc(1, 6'd0, 0, 1, 4'd0, CW_FR,  0);
    cyc(1, 6'd0, 0, 1, 4'd1, CW_DEC, 0);
    cyc(1, 6'd0, 0, 1, 4'd6, CW_EX,  0);
    cyc(1, 6'd0, 0, 1, 4'd7, CW_AWB, 0);
    cyc(1, 6'd0, 0, 0, 4'd0, CW_FS,  1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain cycle=%0d actual=%0d required=0", cyc_n, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM that sequences the shared-memory MIPS datapath through fetch, decode, execute, memory and writeback steps for R-type, lw, sw and beq. It replaces per-instruction combinational decode with a per-state control vector. It stalls on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions. It sits between the instruction register's opcode field, the ALU zero flag, the memory ready line and every datapath mux and write enable.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- OpCode  in  6  IR[31:26], stable from DECODE until the next FETCH
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- PCwe  out  1  PC write enable
- IRwe  out  1  IR write enable
- RFwe  out  1  register file write enable
- DMwe  out  1  memory write strobe
- DMre  out  1  memory read strobe
- ALUS  out  2  ALU op: 0 add, 1 sub, 2 use funct field
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- ALUSrcA  out  1  0 PC, 1 register A
- ALUSrcB  out  2  0 register B, 1 constant 4, 2 sign-ext imm, 3 sign-ext imm<<2
- RegDst  out  1  0 rt, 1 rd
- MemtoReg  out  1  0 ALUOut, 1 MDR
- PCSrc  out  1  0 ALU result, 1 ALUOut
- trap  out  1  unsupported opcode seen; sticky until reset
- state  out  4  current state code (debug)
- retired  out  32  retired instruction count

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, TRAP 9. Codes 10-15 are illegal and return to FETCH on the next edge.
- Outputs are 0 unless listed for the current state.
- FETCH: DMre=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUS=0.
  - If mem_ready=1: IRwe=1 and PCwe=1 (combinational on mem_ready), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUS=0 (precomputes the branch target).
  - OpCode 0 → EXEC; 35 or 43 → MEMADR; 4 → BRANCH; any other value → TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUS=0. OpCode 35 → MEMRD, otherwise → MEMWR.
- MEMRD: DMre=1, IorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RFwe=1, RegDst=0, MemtoReg=1. Retire, then go to FETCH.
- MEMWR: DMwe=1, IorD=1. Wait for mem_ready, then retire and go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUS=2, then go to ALUWB.
- ALUWB: RFwe=1, RegDst=1, MemtoReg=0. Retire, then go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUS=1, PCSrc=1, PCwe=Zero. Retire (taken or not), then go to FETCH.
- TRAP: trap=1 and all other outputs 0. The block stays in TRAP until rst_n is asserted.
- retired: increments by 1 on each retire edge and wraps from 0xFFFFFFFF to 0. It does not count in TRAP.

## Timing
- While rst_n=0: state=FETCH (code 0), retired=0, trap=0, and every control output is forced to 0 (gated by rst_n).
- The first FETCH strobe appears in the first cycle after rst_n deasserts.
- Reset asserted mid-operation (including during a pending MEMWR/MEMRD): outputs drop to 0 immediately and no partial retire is counted.
- Latency with mem_ready held high, in clocks from FETCH entry to the next FETCH entry:
  - beq: 3
  - R-type: 4
  - sw: 4
  - lw: 5
- Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While stalled, DMre/DMwe, IorD, ALUSrcA, ALUSrcB and ALUS are held constant.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- PCwe and IRwe are Mealy outputs (they depend on mem_ready or Zero). All other outputs depend only on state.

## Test plan
- R-type (OpCode=0), mem_ready=1 → state sequence 0,1,6,7,0; RFwe=1 with RegDst=1 only in state 7; retired goes 0→1.
- lw (35), mem_ready low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0; DMre=1 and IorD=1 held through all three MEMRD cycles; MemtoReg=1 in state 4.
- sw (43), mem_ready low 1 cycle in FETCH → FETCH lasts 2 cycles; IRwe pulses once; DMwe=1 in state 5; RFwe never asserted; retired +1.
- beq (4), Zero=1 then Zero=0 → PCwe=1 with PCSrc=1 in state 8 for the first, PCwe=0 for the second; both increment retired.
- OpCode=2 → after DECODE, state=9 and trap=1; all strobes stay 0 for 20 cycles; retired unchanged; rst_n pulse clears trap and returns state to 0.
- rst_n asserted in MEMWR with DMwe=1 → DMwe drops in the same cycle; after release, state=0 and retired=0.
